fetch_stall_ctrl: RTL and testbench



---
 rtl/fetch_stall_ctrl.sv | 107 ++++++++++
 tb/tb_fetch_stall_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl
//   Fetch-side owner of the PC register, the IF/ID pipeline register and the
//   ID/EX bubble select. It honours the ID-stage load-use stall request,
//   applies taken-branch redirects with an IF/ID flush, and freezes fetch for
//   good once a HALT instruction is accepted in ID.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall_req       load-use stall request (combinational, same cycle)
//   imem_instr      instruction memory read data for imem_addr
//   branch_taken    EX-stage taken branch/jump this cycle
//   branch_target   redirect address when branch_taken=1
//   imem_addr       current PC, drives instruction memory
//   ifid_instr      IF/ID registered instruction
//   ifid_pc_next    IF/ID registered PC+PC_INC of that instruction
//   ifid_valid      IF/ID holds a real instruction (0 = bubble)
//   idex_bubble     1 = ID must zero the ID/EX control fields this cycle
//   cpu_halted      1 once HALT has been accepted
//   stall_count     saturating count of honoured stall cycles

module fetch_stall_ctrl #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              PC_INC   = 2,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_req,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_next,
  output logic               ifid_valid,
  output logic               idex_bubble,
  output logic               cpu_halted,
  output logic [15:0]        stall_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus;
  logic            halt_seen;

  // Sequential successor wraps naturally modulo 2^PC_W.
  assign pc_plus   = pc + PC_W'(PC_INC);
  assign halt_seen = ifid_valid && (ifid_instr[INSTR_W-1 -: 4] == HALT_OP);
  assign imem_addr = pc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state: HALT is only accepted when neither a squashing branch nor a
  // stall is in effect, and HALTED is left only through reset.
  always_comb begin
    state_next = state;
    if (state == RUN && !branch_taken && !stall_req && halt_seen)
      state_next = HALTED;
  end

  // Outputs. A taken branch squashes the instruction sitting in ID, and an
  // invalid IF/ID (post-reset, post-flush, halted) must also become a NOP.
  always_comb begin
    idex_bubble = ((state == RUN) && !branch_taken && stall_req) ||
                  branch_taken || !ifid_valid;
    cpu_halted  = (state == HALTED);
  end

  // PC, IF/ID and stall counter. Priority in RUN is branch, stall, halt,
  // then sequential fetch. In HALTED everything holds; ifid_valid was
  // already cleared on the halt edge and no path sets it again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      ifid_instr   <= '0;
      ifid_pc_next <= '0;
      ifid_valid   <= 1'b0;
      stall_count  <= '0;
    end else if (state == RUN) begin
      if (branch_taken) begin
        pc         <= branch_target;
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end else if (stall_req) begin
        if (stall_count != 16'hFFFF)
          stall_count <= stall_count + 16'd1;
      end else if (halt_seen) begin
        ifid_valid <= 1'b0;
      end else begin
        pc           <= pc_plus;
        ifid_instr   <= imem_instr;
        ifid_pc_next <= pc_plus;
        ifid_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb_fetch_stall_ctrl
//   Directed bench for fetch_stall_ctrl. A small combinational instruction
//   memory answers imem_addr; each scenario task drives inputs just after a
//   rising edge and compares outputs 1 time unit after the following edge.

module tb_fetch_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_req;
  logic [15:0] imem_instr;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_next;
  logic        ifid_valid;
  logic        idex_bubble;
  logic        cpu_halted;
  logic [15:0] stall_count;

  int passed = 0;
  int total  = 0;

  fetch_stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .imem_instr   (imem_instr),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .ifid_instr   (ifid_instr),
    .ifid_pc_next (ifid_pc_next),
    .ifid_valid   (ifid_valid),
    .idex_bubble  (idex_bubble),
    .cpu_halted   (cpu_halted),
    .stall_count  (stall_count)
  );

  // Instruction memory contents; address 0x0080 holds the HALT.
  function automatic logic [15:0] mem_at(input logic [15:0] a);
    case (a)
      16'h0000: mem_at = 16'h1234;
      16'h0002: mem_at = 16'h2345;
      16'h0004: mem_at = 16'h3456;
      16'h0006: mem_at = 16'h4567;
      16'h0080: mem_at = 16'hF000;
      default:  mem_at = {4'h1, a[11:0]};
    endcase
  endfunction

  assign imem_instr = mem_at(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_req = 1'b0; branch_taken = 1'b0; branch_target = '0;
    tick(); tick();
    total++; if (imem_addr !== 16'h0000) $display("[TB] FAIL reset_pc: got %h expected 0000", imem_addr); else passed++;
    total++; if (ifid_instr !== 16'h0000) $display("[TB] FAIL reset_instr: got %h expected 0000", ifid_instr); else passed++;
    total++; if (ifid_pc_next !== 16'h0000) $display("[TB] FAIL reset_pc_next: got %h expected 0000", ifid_pc_next); else passed++;
    total++; if (ifid_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", ifid_valid); else passed++;
    total++; if (cpu_halted !== 1'b0) $display("[TB] FAIL reset_halted: got %b expected 0", cpu_halted); else passed++;
    total++; if (stall_count !== 16'h0000) $display("[TB] FAIL reset_stall_count: got %h expected 0000", stall_count); else passed++;
    rst = 1'b0;
    #1;
    total++; if (idex_bubble !== 1'b1) $display("[TB] FAIL reset_bubble: got %b expected 1", idex_bubble); else passed++;
  endtask

  task automatic test_sequential();
    tick();
    total++; if (imem_addr !== 16'h0002) $display("[TB] FAIL seq1_pc: got %h expected 0002", imem_addr); else passed++;
    total++; if (ifid_instr !== 16'h1234) $display("[TB] FAIL seq1_instr: got %h expected 1234", ifid_instr); else passed++;
    total++; if (ifid_pc_next !== 16'h0002) $display("[TB] FAIL seq1_pc_next: got %h expected 0002", ifid_pc_next); else passed++;
    total++; if (ifid_valid !== 1'b1) $display("[TB] FAIL seq1_valid: got %b expected 1", ifid_valid); else passed++;
    total++; if (idex_bubble !== 1'b0) $display("[TB] FAIL seq1_bubble: got %b expected 0", idex_bubble); else passed++;
    tick();
    total++; if (imem_addr !== 16'h0004) $display("[TB] FAIL seq2_pc: got %h expected 0004", imem_addr); else passed++;
    total++; if (ifid_instr !== 16'h2345) $display("[TB] FAIL seq2_instr: got %h expected 2345", ifid_instr); else passed++;
    total++; if (ifid_pc_next !== 16'h0004) $display("[TB] FAIL seq2_pc_next: got %h expected 0004", ifid_pc_next); else passed++;
  endtask

  task automatic test_stall();
    stall_req = 1'b1;
    #1;
    total++; if (idex_bubble !== 1'b1) $display("[TB] FAIL stall_bubble0: got %b expected 1", idex_bubble); else passed++;
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++; if (imem_addr !== 16'h0004) $display("[TB] FAIL stall_pc%0d: got %h expected 0004", i, imem_addr); else passed++;
      total++; if (ifid_instr !== 16'h2345) $display("[TB] FAIL stall_instr%0d: got %h expected 2345", i, ifid_instr); else passed++;
      total++; if (ifid_valid !== 1'b1) $display("[TB] FAIL stall_valid%0d: got %b expected 1", i, ifid_valid); else passed++;
      total++; if (idex_bubble !== 1'b1) $display("[TB] FAIL stall_bubble%0d: got %b expected 1", i, idex_bubble); else passed++;
      total++; if (stall_count !== 16'(i)) $display("[TB] FAIL stall_count%0d: got %h expected %h", i, stall_count, 16'(i)); else passed++;
    end
    stall_req = 1'b0;
    #1;
    total++; if (idex_bubble !== 1'b0) $display("[TB] FAIL stall_release_bubble: got %b expected 0", idex_bubble); else passed++;
    tick();
    total++; if (imem_addr !== 16'h0006) $display("[TB] FAIL stall_resume_pc: got %h expected 0006", imem_addr); else passed++;
    total++; if (ifid_instr !== 16'h3456) $display("[TB] FAIL stall_resume_instr: got %h expected 3456", ifid_instr); else passed++;
    total++; if (ifid_pc_next !== 16'h0006) $display("[TB] FAIL stall_resume_pc_next: got %h expected 0006", ifid_pc_next); else passed++;
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 16'h0040; stall_req = 1'b1;
    #1;
    total++; if (idex_bubble !== 1'b1) $display("[TB] FAIL br_bubble: got %b expected 1", idex_bubble); else passed++;
    tick();
    total++; if (imem_addr !== 16'h0040) $display("[TB] FAIL br_pc: got %h expected 0040", imem_addr); else passed++;
    total++; if (ifid_valid !== 1'b0) $display("[TB] FAIL br_valid: got %b expected 0", ifid_valid); else passed++;
    total++; if (ifid_instr !== 16'h0000) $display("[TB] FAIL br_flush_instr: got %h expected 0000", ifid_instr); else passed++;
    total++; if (stall_count !== 16'h0002) $display("[TB] FAIL br_stall_count: got %h expected 0002", stall_count); else passed++;
    branch_taken = 1'b0; stall_req = 1'b0;
    #1;
    total++; if (idex_bubble !== 1'b1) $display("[TB] FAIL br_flush_bubble: got %b expected 1", idex_bubble); else passed++;
    tick();
    total++; if (ifid_instr !== 16'h1040) $display("[TB] FAIL br_target_instr: got %h expected 1040", ifid_instr); else passed++;
    total++; if (ifid_pc_next !== 16'h0042) $display("[TB] FAIL br_target_pc_next: got %h expected 0042", ifid_pc_next); else passed++;
    total++; if (ifid_valid !== 1'b1) $display("[TB] FAIL br_target_valid: got %b expected 1", ifid_valid); else passed++;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    tick();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 16'hFFFE) $display("[TB] FAIL wrap_setup_pc: got %h expected fffe", imem_addr); else passed++;
    tick();
    total++; if (imem_addr !== 16'h0000) $display("[TB] FAIL wrap_pc: got %h expected 0000", imem_addr); else passed++;
    total++; if (ifid_pc_next !== 16'h0000) $display("[TB] FAIL wrap_pc_next: got %h expected 0000", ifid_pc_next); else passed++;
    total++; if (ifid_instr !== 16'h1FFE) $display("[TB] FAIL wrap_instr: got %h expected 1ffe", ifid_instr); else passed++;
  endtask

  task automatic test_saturation();
    // Counter enters at 2; 65532 more stalls brings it to 0xFFFE.
    stall_req = 1'b1;
    for (int i = 0; i < 65532; i++) tick();
    total++; if (stall_count !== 16'hFFFE) $display("[TB] FAIL sat_fffe: got %h expected fffe", stall_count); else passed++;
    tick();
    total++; if (stall_count !== 16'hFFFF) $display("[TB] FAIL sat_ffff: got %h expected ffff", stall_count); else passed++;
    tick();
    total++; if (stall_count !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h expected ffff", stall_count); else passed++;
    total++; if (imem_addr !== 16'h0000) $display("[TB] FAIL sat_pc_hold: got %h expected 0000", imem_addr); else passed++;
    stall_req = 1'b0;
  endtask

  task automatic test_halt();
    branch_taken = 1'b1; branch_target = 16'h0080;
    tick();
    branch_taken = 1'b0;
    tick();
    total++; if (ifid_instr !== 16'hF000) $display("[TB] FAIL halt_fetch_instr: got %h expected f000", ifid_instr); else passed++;
    total++; if (idex_bubble !== 1'b0) $display("[TB] FAIL halt_in_id_bubble: got %b expected 0", idex_bubble); else passed++;
    total++; if (cpu_halted !== 1'b0) $display("[TB] FAIL halt_early: got %b expected 0", cpu_halted); else passed++;
    tick();
    total++; if (cpu_halted !== 1'b1) $display("[TB] FAIL halt_flag: got %b expected 1", cpu_halted); else passed++;
    total++; if (imem_addr !== 16'h0082) $display("[TB] FAIL halt_pc: got %h expected 0082", imem_addr); else passed++;
    total++; if (ifid_valid !== 1'b0) $display("[TB] FAIL halt_valid: got %b expected 0", ifid_valid); else passed++;
    total++; if (idex_bubble !== 1'b1) $display("[TB] FAIL halt_bubble: got %b expected 1", idex_bubble); else passed++;
    branch_taken = 1'b1; branch_target = 16'h1234; stall_req = 1'b1;
    tick(); tick();
    total++; if (imem_addr !== 16'h0082) $display("[TB] FAIL halted_pc_frozen: got %h expected 0082", imem_addr); else passed++;
    total++; if (cpu_halted !== 1'b1) $display("[TB] FAIL halted_stays: got %b expected 1", cpu_halted); else passed++;
    total++; if (stall_count !== 16'hFFFF) $display("[TB] FAIL halted_stall_count: got %h expected ffff", stall_count); else passed++;
    total++; if (ifid_instr !== 16'hF000) $display("[TB] FAIL halted_ifid_hold: got %h expected f000", ifid_instr); else passed++;
    total++; if (ifid_valid !== 1'b0) $display("[TB] FAIL halted_valid: got %b expected 0", ifid_valid); else passed++;
  endtask

  task automatic test_async_reset();
    // Assert reset well between edges and look before the next edge arrives.
    #2;
    rst = 1'b1;
    #1;
    total++; if (imem_addr !== 16'h0000) $display("[TB] FAIL arst_pc: got %h expected 0000", imem_addr); else passed++;
    total++; if (cpu_halted !== 1'b0) $display("[TB] FAIL arst_halted: got %b expected 0", cpu_halted); else passed++;
    total++; if (stall_count !== 16'h0000) $display("[TB] FAIL arst_stall_count: got %h expected 0000", stall_count); else passed++;
    total++; if (ifid_instr !== 16'h0000) $display("[TB] FAIL arst_instr: got %h expected 0000", ifid_instr); else passed++;
    total++; if (ifid_pc_next !== 16'h0000) $display("[TB] FAIL arst_pc_next: got %h expected 0000", ifid_pc_next); else passed++;
    total++; if (ifid_valid !== 1'b0) $display("[TB] FAIL arst_valid: got %b expected 0", ifid_valid); else passed++;
    branch_taken = 1'b0; stall_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    total++; if (imem_addr !== 16'h0002) $display("[TB] FAIL arst_restart_pc: got %h expected 0002", imem_addr); else passed++;
    total++; if (ifid_instr !== 16'h1234) $display("[TB] FAIL arst_restart_instr: got %h expected 1234", ifid_instr); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
    test_saturation();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
